// File: rtl/jfpjc_pkg.sv
// Shared JPEG-pipeline constants, types and width helpers used by the
// camera ingester and the MCU block reader.
package jfpjc_pkg;

  localparam int unsigned MCU_DIM     = 8;
  localparam int unsigned PIX_PER_MCU = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } reader_state_e;

  typedef struct packed {
    logic       stripe_end;
    logic       mcu_start;
    logic [7:0] data;
  } pix_beat_t;

  function automatic int unsigned slot_width(input int unsigned ebr_size);
    return (ebr_size / PIX_PER_MCU > 1) ? $clog2(ebr_size / PIX_PER_MCU) : 1;
  endfunction

  function automatic int unsigned blk_sel_width(input int unsigned num_ebr);
    return (num_ebr > 1) ? $clog2(num_ebr) : 1;
  endfunction

endpackage

// File: rtl/byte_skid_fifo.sv
// Two-entry fall-through FIFO carrying pixel bytes with their sideband flags;
// an empty FIFO passes the incoming beat straight to the output.
module byte_skid_fifo
  import jfpjc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  pix_beat_t push_data_i,
  output logic      out_valid_o,
  output pix_beat_t out_data_o,
  input  logic      out_ready_i,
  output logic [1:0] count_o
);

  pix_beat_t  mem_q [2];
  logic       rd_ptr_q;
  logic       wr_ptr_q;
  logic [1:0] count_q;

  logic pop;
  logic bypass;
  logic store;
  logic deq;

  always_comb begin
    out_valid_o = (count_q != 2'd0) || push_i;
    out_data_o  = '0;
    if (count_q != 2'd0) begin
      out_data_o = mem_q[rd_ptr_q];
    end else if (push_i) begin
      out_data_o = push_data_i;
    end
    pop    = out_valid_o && out_ready_i;
    // A beat arriving at an empty FIFO that is consumed at once is never stored.
    bypass = (count_q == 2'd0) && push_i && out_ready_i;
    store  = push_i && !bypass;
    deq    = pop && (count_q != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (store) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (deq) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(store) - 2'(deq);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mcu_block_reader.sv
// Reads a completed 8-row stripe from the idle EBR buffer and streams it
// MCU by MCU (raster order inside each 8x8 block) to the JPEG datapath.
module mcu_block_reader
  import jfpjc_pkg::*;
#(
  parameter int unsigned width_pix = 320,
  parameter int unsigned num_ebr   = 5,
  parameter int unsigned ebr_size  = 512
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               frontbuffer_select,
  output logic                               read_en,
  output logic                               read_buffer_select,
  output logic [blk_sel_width(num_ebr)-1:0]  read_block_select,
  output logic [$clog2(ebr_size)-1:0]        read_addr,
  input  logic [7:0]                         read_data,
  output logic [7:0]                         out_pixval,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_mcu_start,
  output logic                               out_stripe_end,
  output logic                               busy,
  output logic                               overrun
);

  localparam int unsigned BLK_W  = blk_sel_width(num_ebr);
  localparam int unsigned SLOT_W = slot_width(ebr_size);
  localparam int unsigned ADDR_W = $clog2(ebr_size);
  localparam int unsigned MCUS   = width_pix / MCU_DIM;
  localparam int unsigned MX_W   = (MCUS > 1) ? $clog2(MCUS) : 1;
  localparam logic [MX_W-1:0]  MCUX_LAST = MX_W'(MCUS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(num_ebr - 1);

  reader_state_e     state_q, state_d;
  logic              fb_prev_q;
  logic              rbs_q, rbs_d;
  logic [2:0]        px_q, px_d;
  logic [2:0]        py_q, py_d;
  logic [MX_W-1:0]   mcux_q, mcux_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              overrun_q, overrun_d;
  logic              inflight_q;
  logic [1:0]        side_q;

  logic       toggle;
  logic       is_last;
  logic       first_px;
  logic [1:0] fifo_count;
  logic [1:0] outstanding;
  logic       fifo_pop;
  logic       drain_done;
  pix_beat_t  push_beat;
  pix_beat_t  head_beat;

  byte_skid_fifo u_fifo (
    .clk         (clock),
    .rst         (reset),
    .push_i      (inflight_q),
    .push_data_i (push_beat),
    .out_valid_o (out_valid),
    .out_data_o  (head_beat),
    .out_ready_i (out_ready),
    .count_o     (fifo_count)
  );

  always_comb begin
    push_beat = '{stripe_end: side_q[1], mcu_start: side_q[0], data: read_data};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fb_prev_q  <= 1'b0;
      rbs_q      <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      mcux_q     <= '0;
      blk_q      <= '0;
      slot_q     <= '0;
      overrun_q  <= 1'b0;
      inflight_q <= 1'b0;
      side_q     <= '0;
    end else begin
      state_q    <= state_d;
      fb_prev_q  <= frontbuffer_select;
      rbs_q      <= rbs_d;
      px_q       <= px_d;
      py_q       <= py_d;
      mcux_q     <= mcux_d;
      blk_q      <= blk_d;
      slot_q     <= slot_d;
      overrun_q  <= overrun_d;
      inflight_q <= read_en;
      side_q     <= read_en ? {is_last, first_px} : 2'b00;
    end
  end

  always_comb begin
    toggle      = frontbuffer_select != fb_prev_q;
    is_last     = (mcux_q == MCUX_LAST) && (py_q == 3'd7) && (px_q == 3'd7);
    first_px    = (py_q == 3'd0) && (px_q == 3'd0);
    outstanding = fifo_count + 2'(inflight_q);
    fifo_pop    = out_valid && out_ready;
    // Done once everything still owed leaves this cycle, so busy drops right after the last byte.
    drain_done  = (outstanding == 2'd0) || ((outstanding == 2'd1) && fifo_pop);

    state_d   = state_q;
    rbs_d     = rbs_q;
    px_d      = px_q;
    py_d      = py_q;
    mcux_d    = mcux_q;
    blk_d     = blk_q;
    slot_d    = slot_q;
    overrun_d = overrun_q;

    unique case (state_q)
      ST_IDLE: begin
        if (toggle) begin
          state_d = ST_READ;
          rbs_d   = fb_prev_q;
          px_d    = '0;
          py_d    = '0;
          mcux_d  = '0;
          blk_d   = '0;
          slot_d  = '0;
        end
      end
      ST_READ: begin
        if (toggle) begin
          overrun_d = 1'b1;
        end
        if (read_en) begin
          if (px_q == 3'd7) begin
            px_d = '0;
            if (py_q == 3'd7) begin
              py_d = '0;
              if (mcux_q == MCUX_LAST) begin
                mcux_d = '0;
                blk_d  = '0;
                slot_d = '0;
              end else begin
                mcux_d = mcux_q + MX_W'(1);
                if (blk_q == BLK_LAST) begin
                  blk_d  = '0;
                  slot_d = slot_q + SLOT_W'(1);
                end else begin
                  blk_d = blk_q + BLK_W'(1);
                end
              end
            end else begin
              py_d = py_q + 3'd1;
            end
          end else begin
            px_d = px_q + 3'd1;
          end
          if (is_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          if (toggle) begin
            state_d = ST_READ;
            rbs_d   = fb_prev_q;
            px_d    = '0;
            py_d    = '0;
            mcux_d  = '0;
            blk_d   = '0;
            slot_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (toggle) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    read_en            = (state_q == ST_READ) && (outstanding < 2'd2);
    read_buffer_select = rbs_q;
    read_block_select  = blk_q;
    read_addr          = ADDR_W'({slot_q, py_q, px_q});
    busy               = state_q != ST_IDLE;
    overrun            = overrun_q;
    out_pixval         = head_beat.data;
    out_mcu_start      = head_beat.mcu_start;
    out_stripe_end     = head_beat.stripe_end;
  end

endmodule
